regfile_wb_arbiter: RTL and testbench

- Writer-side front end for the single write port of the 32x32 register file.
- Merges two writeback sources into one write stream and drives RegWrite / Write_addr / Write_data:
  - Source A: single-cycle ALU results. Priority source, never stalled.
  - Source B: multi-cycle load/mul-div results. Buffered in a small FIFO with a valid/ready handshake.
- Publishes a pending-write scoreboard that the hazard unit uses to stall reads of registers that still have a B write in flight.

---
 rtl/regfile_wb_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Single write port front end for the register file: merges the ALU writeback (A) with a
// buffered multi-cycle writeback stream (B) and publishes which registers still have B writes pending.
module regfile_wb_arbiter #(
  parameter int bit_size = 32,
  parameter int depth    = 4,
  parameter int cnt_w    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  input  logic [4:0]          a_addr,
  input  logic [bit_size-1:0] a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [4:0]          b_addr,
  input  logic [bit_size-1:0] b_data,
  output logic                RegWrite,
  output logic [4:0]          Write_addr,
  output logic [bit_size-1:0] Write_data,
  output logic [31:0]         busy_mask,
  output logic [cnt_w-1:0]    fifo_count
);

  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;

  logic [4:0]          r_addr   [depth];
  logic [bit_size-1:0] r_data   [depth];
  logic                r_valid  [depth];
  logic                r_cancel [depth];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [cnt_w-1:0]    r_count;

  logic                w_push;
  logic                w_pop;
  logic [4:0]          w_head_addr;
  logic [bit_size-1:0] w_head_data;
  logic                w_head_cancel;

  assign b_ready       = (r_count < cnt_w'(depth));
  assign w_push        = b_valid && b_ready;
  assign w_pop         = !a_valid && (r_count != '0);
  assign w_head_addr   = r_addr[r_head];
  assign w_head_data   = r_data[r_head];
  assign w_head_cancel = r_cancel[r_head];
  assign fifo_count    = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)
        r_head <= (r_head == PTR_W'(depth - 1)) ? '0 : r_head + 1'b1;
      if (w_push)
        r_tail <= (r_tail == PTR_W'(depth - 1)) ? '0 : r_tail + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A push only ever lands on a free slot, so it never collides with a pop or a cancel
  // of the same entry; a freshly pushed entry is younger than a same-edge A write.
  generate
    for (genvar gi = 0; gi < depth; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_valid[gi]  <= 1'b0;
          r_cancel[gi] <= 1'b0;
          r_addr[gi]   <= '0;
          r_data[gi]   <= '0;
        end else if (w_push && (r_tail == PTR_W'(gi))) begin
          r_valid[gi]  <= 1'b1;
          r_cancel[gi] <= 1'b0;
          r_addr[gi]   <= b_addr;
          r_data[gi]   <= b_data;
        end else begin
          if (w_pop && (r_head == PTR_W'(gi)))
            r_valid[gi] <= 1'b0;
          if (a_valid && r_valid[gi] && (r_addr[gi] == a_addr))
            r_cancel[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < depth; i++) begin
      if (r_valid[i] && !r_cancel[i])
        busy_mask[r_addr[i]] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite   <= 1'b0;
      Write_addr <= '0;
      Write_data <= '0;
    end else if (a_valid) begin
      RegWrite   <= (a_addr != 5'd0);
      Write_addr <= a_addr;
      Write_data <= a_data;
    end else if (r_count != '0) begin
      RegWrite   <= (w_head_addr != 5'd0) && !w_head_cancel;
      Write_addr <= w_head_addr;
      Write_data <= w_head_data;
    end else begin
      RegWrite   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int BS    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0;
  logic [4:0]    a_addr = '0;
  logic [BS-1:0] a_data = '0;
  logic          b_valid = 1'b0;
  logic [4:0]    b_addr = '0;
  logic [BS-1:0] b_data = '0;
  logic          b_ready;
  logic          RegWrite;
  logic [4:0]    Write_addr;
  logic [BS-1:0] Write_data;
  logic [31:0]   busy_mask;
  logic [CW-1:0] fifo_count;

  regfile_wb_arbiter #(.bit_size(BS), .depth(DEPTH), .cnt_w(CW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .RegWrite(RegWrite), .Write_addr(Write_addr), .Write_data(Write_data),
    .busy_mask(busy_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    addr;
    logic [BS-1:0] data;
    bit            cancel;
  } bent_t;

  typedef struct {
    bit            we;
    logic [4:0]    addr;
    logic [BS-1:0] data;
  } out_t;

  bent_t         mq[$];
  out_t          sb[$];
  out_t          m_out = '{1'b0, 5'd0, '0};
  logic [BS-1:0] model_rf [32];
  logic [BS-1:0] dut_rf   [32];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n0;
  bent_t         e;
  out_t          x;
  logic [31:0]   bm;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: B results wait in a plain queue, A always wins the port.
  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_out = '{1'b0, 5'd0, '0};
      sb.push_back(m_out);
    end else begin
      n0 = mq.size();
      if (a_valid) begin
        m_out = '{(a_addr != 5'd0), a_addr, a_data};
        foreach (mq[i]) if (mq[i].addr == a_addr) mq[i].cancel = 1'b1;
      end else if (n0 > 0) begin
        e = mq.pop_front();
        m_out = '{(e.addr != 5'd0) && !e.cancel, e.addr, e.data};
      end else begin
        m_out.we = 1'b0;
      end
      if (m_out.we) model_rf[m_out.addr] = m_out.data;
      if (b_valid && n0 < DEPTH) mq.push_back('{b_addr, b_data, 1'b0});
      sb.push_back(m_out);
    end
  end

  always @(negedge clk) begin
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL sb_underflow: got no expected output at %0t", $time);
    end else begin
      x = sb.pop_front();
      chk("RegWrite", RegWrite, x.we);
      chk("Write_addr", Write_addr, x.addr);
      chk("Write_data", Write_data, x.data);
    end
    if (RegWrite === 1'b1) begin
      dut_rf[Write_addr] = Write_data;
      $display("[TB] t=%0t write r%0d = %h", $time, Write_addr, Write_data);
    end
    bm = '0;
    foreach (mq[i]) if (!mq[i].cancel && mq[i].addr != 5'd0) bm[mq[i].addr] = 1'b1;
    chk("fifo_count", fifo_count, mq.size());
    chk("b_ready", b_ready, (mq.size() < DEPTH));
    chk("busy_mask", busy_mask, bm);
  end

  task automatic cyc(input bit av, input logic [4:0] aa, input logic [BS-1:0] ad,
                     input bit bv, input logic [4:0] ba, input logic [BS-1:0] bd);
    @(negedge clk);
    #2;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      model_rf[i] = '0;
      dut_rf[i]   = '0;
    end
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    idle(2);

    cyc(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, '0);
    idle(2);

    cyc(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'hCAFE);
    idle(3);

    for (int k = 2; k <= 5; k++)
      cyc(1'b1, 5'd1, 32'h100 + k, 1'b1, 5'(k), 32'hB000 + k);
    cyc(1'b1, 5'd1, 32'h106, 1'b1, 5'd6, 32'hB006);
    idle(6);

    cyc(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'hAAAA);
    cyc(1'b1, 5'd7, 32'hBBBB, 1'b0, 5'd0, '0);
    idle(3);
    chk("rf7_after_cancel", dut_rf[7], 32'hBBBB);

    cyc(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, '0);
    idle(2);

    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom);
    idle(8);

    for (int k = 0; k < 3; k++)
      cyc(1'b1, 5'd1, 32'h200 + k, 1'b1, 5'(10 + k), 32'hC000 + k);
    @(negedge clk);
    #2;
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("cnt_before_rst", fifo_count, 3);
    rst = 1'b0;
    mq.delete();
    sb.delete();
    #1;
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_busy_mask", busy_mask, 0);
    chk("rst_Write_addr", Write_addr, 0);
    chk("rst_Write_data", Write_data, 0);
    #3 rst = 1'b1;
    idle(4);

    chk("sb_drained", sb.size(), 0);
    for (int r = 1; r < 32; r++)
      chk($sformatf("regfile_r%0d", r), dut_rf[r], model_rf[r]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
